// File: rtl/adc_multi_capture.sv
// Trigger-driven burst reader for NCH serial ADCs sharing CNV/SCK, with optional 2^n averaging.
// Result strobes (2^n-1)*P+E+1 edges after the trigger edge; triggers during a burst are dropped and flagged.
module adc_multi_capture #(
    parameter int NCH      = 2,
    parameter int DW       = 14,
    parameter int OUT_W    = 16,
    parameter int CONV_CYC = 22,
    parameter int SCK_DIV  = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 trigger,
    input  logic [1:0]           avg_log2,
    input  logic [NCH-1:0]       adc_sdo,
    output logic                 adc_cnv,
    output logic                 adc_sck,
    output logic                 busy,
    output logic                 overrun,
    output logic                 data_valid,
    output logic [NCH*OUT_W-1:0] data_value
);
    localparam int AW      = DW + 3;
    localparam int CNT_W   = $clog2(CONV_CYC + 1);
    localparam int DIV_W   = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam int BIT_W   = (DW > 1) ? $clog2(DW) : 1;
    localparam int DIV_END = (SCK_DIV > 1) ? SCK_DIV - 2 : 0;

    typedef enum logic [2:0] {IDLE, CONV, SHIFT, ACC, RECOVER, DONE} state_t;

    state_t               state, state_nxt;
    logic                 trig_d;
    logic                 rise;
    logic [CNT_W-1:0]     conv_cnt, conv_cnt_nxt;
    logic [DIV_W-1:0]     div_cnt, div_cnt_nxt;
    logic [BIT_W-1:0]     bit_cnt, bit_cnt_nxt;
    logic [2:0]           burst_cnt, burst_cnt_nxt;
    logic [1:0]           avg_l, avg_l_nxt;
    logic [DW-1:0]        shreg [NCH];
    logic [DW-1:0]        shreg_nxt [NCH];
    logic [AW-1:0]        acc [NCH];
    logic [AW-1:0]        acc_nxt [NCH];
    logic                 cnv_nxt, sck_nxt, busy_nxt, overrun_nxt, data_valid_nxt;
    logic [NCH*OUT_W-1:0] data_value_nxt;
    logic                 last_conv;
    logic                 shift_end;

    assign rise      = trigger & ~trig_d;
    assign last_conv = ({1'b0, burst_cnt} == ((4'd1 << avg_l) - 4'd1));

    // With SCK_DIV=1 the final fall and the hand-off to ACC share an edge; otherwise
    // ACC is entered one cycle before the last low phase would end.
    assign shift_end = (bit_cnt == BIT_W'(DW - 1)) &&
                       ((SCK_DIV == 1) ? adc_sck : (!adc_sck && div_cnt == DIV_W'(DIV_END)));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            trig_d     <= 1'b0;
            conv_cnt   <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            burst_cnt  <= '0;
            avg_l      <= '0;
            adc_cnv    <= 1'b1;
            adc_sck    <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            data_valid <= 1'b0;
            data_value <= '0;
            for (int i = 0; i < NCH; i++) begin
                shreg[i] <= '0;
                acc[i]   <= '0;
            end
        end else begin
            state      <= state_nxt;
            trig_d     <= trigger;
            conv_cnt   <= conv_cnt_nxt;
            div_cnt    <= div_cnt_nxt;
            bit_cnt    <= bit_cnt_nxt;
            burst_cnt  <= burst_cnt_nxt;
            avg_l      <= avg_l_nxt;
            adc_cnv    <= cnv_nxt;
            adc_sck    <= sck_nxt;
            busy       <= busy_nxt;
            overrun    <= overrun_nxt;
            data_valid <= data_valid_nxt;
            data_value <= data_value_nxt;
            for (int i = 0; i < NCH; i++) begin
                shreg[i] <= shreg_nxt[i];
                acc[i]   <= acc_nxt[i];
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        conv_cnt_nxt   = conv_cnt;
        div_cnt_nxt    = div_cnt;
        bit_cnt_nxt    = bit_cnt;
        burst_cnt_nxt  = burst_cnt;
        avg_l_nxt      = avg_l;
        cnv_nxt        = adc_cnv;
        sck_nxt        = adc_sck;
        busy_nxt       = busy;
        overrun_nxt    = rise && (state != IDLE);
        data_valid_nxt = 1'b0;
        data_value_nxt = data_value;
        shreg_nxt      = shreg;
        acc_nxt        = acc;

        case (state)
            IDLE: begin
                if (rise) begin
                    avg_l_nxt     = avg_log2;
                    burst_cnt_nxt = '0;
                    conv_cnt_nxt  = '0;
                    cnv_nxt       = 1'b0;
                    busy_nxt      = 1'b1;
                    for (int i = 0; i < NCH; i++) acc_nxt[i] = '0;
                    state_nxt     = CONV;
                end
            end
            CONV: begin
                if (conv_cnt == CNT_W'(CONV_CYC - 1)) begin
                    sck_nxt     = 1'b1;
                    div_cnt_nxt = '0;
                    bit_cnt_nxt = '0;
                    state_nxt   = SHIFT;
                end else begin
                    conv_cnt_nxt = conv_cnt + CNT_W'(1);
                end
            end
            SHIFT: begin
                if (div_cnt == DIV_W'(SCK_DIV - 1)) begin
                    div_cnt_nxt = '0;
                    if (adc_sck) begin
                        // ADC data is stable through the high phase; capture as SCK falls
                        sck_nxt = 1'b0;
                        for (int i = 0; i < NCH; i++) shreg_nxt[i] = DW'({shreg[i], adc_sdo[i]});
                    end else begin
                        sck_nxt     = 1'b1;
                        bit_cnt_nxt = bit_cnt + BIT_W'(1);
                    end
                end else begin
                    div_cnt_nxt = div_cnt + DIV_W'(1);
                end
                if (shift_end) state_nxt = ACC;
            end
            ACC: begin
                for (int i = 0; i < NCH; i++) acc_nxt[i] = acc[i] + AW'(shreg[i]);
                cnv_nxt      = 1'b1;
                conv_cnt_nxt = '0;
                if (last_conv) begin
                    state_nxt = DONE;
                end else begin
                    burst_cnt_nxt = burst_cnt + 3'd1;
                    state_nxt     = RECOVER;
                end
            end
            RECOVER: begin
                if (conv_cnt == CNT_W'(1)) begin
                    cnv_nxt      = 1'b0;
                    conv_cnt_nxt = '0;
                    state_nxt    = CONV;
                end else begin
                    conv_cnt_nxt = conv_cnt + CNT_W'(1);
                end
            end
            DONE: begin
                for (int i = 0; i < NCH; i++)
                    data_value_nxt[i*OUT_W +: OUT_W] = OUT_W'(acc[i] >> avg_l);
                data_valid_nxt = 1'b1;
                busy_nxt       = 1'b0;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_adc_multi_capture.sv
// Bench for adc_multi_capture: default 2-channel instance plus a 1-channel SCK_DIV=3, DW=12 instance,
// each fed by a behavioural ADC that loads on CNV fall and advances SDO on SCK fall.
module tb_adc_multi_capture;
    localparam int A_DW = 14, A_CONV = 22, A_DIV = 1;
    localparam int B_DW = 12, B_CONV = 5,  B_DIV = 3;

    logic        clk  = 1'b0;
    logic        rstn = 1'b1;

    logic        a_trig = 1'b0;
    logic [1:0]  a_avg  = 2'd0;
    logic [1:0]  a_sdo  = 2'd0;
    logic        a_cnv, a_sck, a_busy, a_ovr, a_dv;
    logic [31:0] a_dval;

    logic        b_trig = 1'b0;
    logic [1:0]  b_avg  = 2'd0;
    logic [0:0]  b_sdo  = 1'b0;
    logic        b_cnv, b_sck, b_busy, b_ovr, b_dv;
    logic [15:0] b_dval;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    adc_multi_capture dut_a (
        .clk(clk), .rstn(rstn), .trigger(a_trig), .avg_log2(a_avg), .adc_sdo(a_sdo),
        .adc_cnv(a_cnv), .adc_sck(a_sck), .busy(a_busy), .overrun(a_ovr),
        .data_valid(a_dv), .data_value(a_dval)
    );

    adc_multi_capture #(.NCH(1), .DW(B_DW), .OUT_W(16), .CONV_CYC(B_CONV), .SCK_DIV(B_DIV)) dut_b (
        .clk(clk), .rstn(rstn), .trigger(b_trig), .avg_log2(b_avg), .adc_sdo(b_sdo),
        .adc_cnv(b_cnv), .adc_sck(b_sck), .busy(b_busy), .overrun(b_ovr),
        .data_valid(b_dv), .data_value(b_dval)
    );

    // Behavioural ADCs: word for conversion k comes from the sample table
    logic [13:0] a_samp [2][8];
    logic [13:0] a_word [2];
    int          a_conv_seen = 0, a_base = 0, a_bit = 0;
    logic        a_cnv_m = 1'b1, a_sck_m = 1'b0;

    always @(a_cnv or a_sck) begin
        if (a_cnv_m === 1'b1 && a_cnv === 1'b0) begin
            for (int c = 0; c < 2; c++) begin
                a_word[c] = a_samp[c][(a_conv_seen - a_base) & 7];
                a_sdo[c]  = a_word[c][13];
            end
            a_conv_seen++;
            a_bit = 13;
        end else if (a_sck_m === 1'b1 && a_sck === 1'b0) begin
            if (a_bit > 0) begin
                a_bit--;
                for (int c = 0; c < 2; c++) a_sdo[c] = a_word[c][a_bit];
            end else begin
                a_sdo = 2'($urandom);
            end
        end
        a_cnv_m = a_cnv;
        a_sck_m = a_sck;
    end

    logic [11:0] b_samp [8];
    logic [11:0] b_word;
    int          b_conv_seen = 0, b_base = 0, b_bit = 0;
    logic        b_cnv_m = 1'b1, b_sck_m = 1'b0;

    always @(b_cnv or b_sck) begin
        if (b_cnv_m === 1'b1 && b_cnv === 1'b0) begin
            b_word   = b_samp[(b_conv_seen - b_base) & 7];
            b_sdo[0] = b_word[11];
            b_conv_seen++;
            b_bit = 11;
        end else if (b_sck_m === 1'b1 && b_sck === 1'b0) begin
            if (b_bit > 0) begin
                b_bit--;
                b_sdo[0] = b_word[b_bit];
            end else begin
                b_sdo = 1'($urandom);
            end
        end
        b_cnv_m = b_cnv;
        b_sck_m = b_sck;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One burst on dut_a; edge r is the r-th clk edge after the trigger is first sampled high.
    task automatic burst_a(input int n, input bit pre_armed, input int retrig_at, input bit chain_out);
        int nconv, e_cyc, p_cyc, dv_exp, sum;
        int dv_at, dv_cnt, ovr_at, ovr_cnt, cnv_low, cnv_falls, last_fall, sck_rises, busy_cnt;
        logic prev_cnv, prev_sck;
        logic [31:0] got, exp_val;
        nconv  = 1 << n;
        e_cyc  = A_CONV + 2 * A_DIV * A_DW;
        p_cyc  = e_cyc + 2;
        dv_exp = (nconv - 1) * p_cyc + e_cyc + 1;
        exp_val = '0;
        for (int c = 0; c < 2; c++) begin
            sum = 0;
            for (int k = 0; k < nconv; k++) sum += int'(a_samp[c][k]);
            exp_val[c*16 +: 16] = 16'(sum >> n);
        end
        a_base = a_conv_seen;
        a_avg  = 2'(n);
        if (!pre_armed) a_trig = 1'b1;
        prev_cnv = 1'b1; prev_sck = 1'b0; got = '0;
        dv_at = -1; dv_cnt = 0; ovr_at = -1; ovr_cnt = 0;
        cnv_low = 0; cnv_falls = 0; last_fall = -1; sck_rises = 0; busy_cnt = 0;
        for (int r = 0; r < dv_exp + 40; r++) begin
            @(posedge clk); #1;
            if (!a_cnv) cnv_low++;
            if (prev_cnv && !a_cnv) begin cnv_falls++; last_fall = r; end
            if (!prev_sck && a_sck) sck_rises++;
            if (a_busy) busy_cnt++;
            if (a_ovr) begin ovr_cnt++; ovr_at = r; end
            if (a_dv) begin
                dv_cnt++;
                if (dv_at < 0) begin dv_at = r; got = a_dval; end
            end
            prev_cnv = a_cnv;
            prev_sck = a_sck;
            if (r == 1) a_avg = ~2'(n);
            if (r == 3) a_trig = 1'b0;
            if (retrig_at > 0 && r == retrig_at - 1) a_trig = 1'b1;
            if (retrig_at > 0 && r == retrig_at + 1) a_trig = 1'b0;
            if (dv_at >= 0 && chain_out) begin a_trig = 1'b1; break; end
            if (dv_at >= 0 && r >= dv_at + 4) break;
        end
        chk("dv_edge", 64'(dv_at), 64'(dv_exp));
        chk("dv_count", 64'(dv_cnt), 64'd1);
        chk("data_value", 64'(got), 64'(exp_val));
        chk("cnv_falls", 64'(cnv_falls), 64'(nconv));
        chk("cnv_low_cycles", 64'(cnv_low), 64'(nconv * e_cyc));
        chk("last_cnv_fall", 64'(last_fall), 64'((nconv - 1) * p_cyc));
        chk("sck_pulses", 64'(sck_rises), 64'(nconv * A_DW));
        chk("busy_cycles", 64'(busy_cnt), 64'(dv_exp));
        chk("overrun_count", 64'(ovr_cnt), (retrig_at > 0) ? 64'd1 : 64'd0);
        if (retrig_at > 0) chk("overrun_edge", 64'(ovr_at), 64'(retrig_at));
    endtask

    task automatic burst_b(input int n);
        int nconv, e_cyc, dv_exp, sum, dv_at, rises, falls, bad, cs, ri, fi;
        logic prev_cnv, prev_sck;
        logic [15:0] got, exp_val;
        nconv  = 1 << n;
        e_cyc  = B_CONV + 2 * B_DIV * B_DW;
        dv_exp = (nconv - 1) * (e_cyc + 2) + e_cyc + 1;
        sum = 0;
        for (int k = 0; k < nconv; k++) sum += int'(b_samp[k]);
        exp_val = 16'(sum >> n);
        b_base = b_conv_seen;
        b_avg  = 2'(n);
        b_trig = 1'b1;
        prev_cnv = 1'b1; prev_sck = 1'b0; got = '0;
        dv_at = -1; rises = 0; falls = 0; bad = 0; cs = 0; ri = 0; fi = 0;
        for (int r = 0; r < dv_exp + 40; r++) begin
            @(posedge clk); #1;
            if (prev_cnv && !b_cnv) begin cs = r; ri = 0; fi = 0; end
            if (!prev_sck && b_sck) begin
                rises++;
                if (r != cs + B_CONV + 2 * B_DIV * ri) bad++;
                ri++;
            end
            if (prev_sck && !b_sck) begin
                falls++;
                if (r != cs + B_CONV + (2 * fi + 1) * B_DIV) bad++;
                fi++;
            end
            if (b_dv && dv_at < 0) begin dv_at = r; got = b_dval; end
            prev_cnv = b_cnv;
            prev_sck = b_sck;
            if (r == 1) b_avg = ~2'(n);
            if (r == 3) b_trig = 1'b0;
            if (dv_at >= 0 && r >= dv_at + 2) break;
        end
        chk("b_dv_edge", 64'(dv_at), 64'(dv_exp));
        chk("b_data_value", 64'(got), 64'(exp_val));
        chk("b_sck_rises", 64'(rises), 64'(nconv * B_DW));
        chk("b_sck_falls", 64'(falls), 64'(nconv * B_DW));
        chk("b_sck_misplaced", 64'(bad), 64'd0);
    endtask

    initial begin
        int dv_seen;
        #2 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cnv", 64'(a_cnv), 64'd1);
        chk("rst_sck", 64'(a_sck), 64'd0);
        chk("rst_busy", 64'(a_busy), 64'd0);
        chk("rst_overrun", 64'(a_ovr), 64'd0);
        chk("rst_dv", 64'(a_dv), 64'd0);
        chk("rst_dval", 64'(a_dval), 64'd0);
        chk("rst_b_cnv", 64'(b_cnv), 64'd1);
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        a_samp[0][0] = 14'h2A5C; a_samp[1][0] = 14'h0001;
        burst_a(0, 1'b0, 0, 1'b0);
        chk("plan_value", 64'(a_dval), 64'h0001_2A5C);

        for (int k = 0; k < 4; k++) begin
            a_samp[0][k] = 14'(100 + k);
            a_samp[1][k] = 14'($urandom);
        end
        burst_a(2, 1'b0, 0, 1'b0);
        chk("avg4_ch0", 64'(a_dval[15:0]), 64'd101);

        for (int k = 0; k < 8; k++) begin
            a_samp[0][k] = 14'h3FFF;
            a_samp[1][k] = 14'h3FFF;
        end
        burst_a(3, 1'b0, 0, 1'b0);
        chk("avg8_full", 64'(a_dval), 64'h3FFF_3FFF);

        for (int k = 0; k < 8; k++) begin
            a_samp[0][k] = (k == 5) ? 14'd7 : 14'd0;
            a_samp[1][k] = 14'($urandom);
        end
        burst_a(3, 1'b0, 0, 1'b0);
        chk("avg8_trunc", 64'(a_dval[15:0]), 64'd0);

        a_samp[0][0] = 14'($urandom); a_samp[1][0] = 14'($urandom);
        burst_a(0, 1'b0, 30, 1'b0);

        for (int k = 0; k < 2; k++) begin
            a_samp[0][k] = 14'($urandom);
            a_samp[1][k] = 14'($urandom);
        end
        burst_a(1, 1'b0, 0, 1'b1);
        a_samp[0][0] = 14'($urandom); a_samp[1][0] = 14'($urandom);
        burst_a(0, 1'b1, 0, 1'b0);

        // Reset right after bit 6 is sampled (edge 22 + 13)
        a_samp[0][0] = 14'($urandom); a_samp[1][0] = 14'($urandom);
        a_base = a_conv_seen;
        a_avg  = 2'd0;
        a_trig = 1'b1;
        for (int r = 0; r <= 35; r++) begin
            @(posedge clk); #1;
            if (r == 3) a_trig = 1'b0;
        end
        chk("pre_rst_busy", 64'(a_busy), 64'd1);
        rstn = 1'b0;
        #1;
        chk("midrst_cnv", 64'(a_cnv), 64'd1);
        chk("midrst_sck", 64'(a_sck), 64'd0);
        chk("midrst_busy", 64'(a_busy), 64'd0);
        chk("midrst_dval", 64'(a_dval), 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        dv_seen = 0;
        repeat (120) begin
            @(posedge clk); #1;
            if (a_dv) dv_seen++;
        end
        chk("midrst_no_dv", 64'(dv_seen), 64'd0);
        chk("midrst_dval_hold", 64'(a_dval), 64'd0);
        a_samp[0][0] = 14'($urandom); a_samp[1][0] = 14'($urandom);
        burst_a(0, 1'b0, 0, 1'b0);

        for (int it = 0; it < 6; it++) begin
            for (int k = 0; k < 8; k++) begin
                a_samp[0][k] = 14'($urandom);
                a_samp[1][k] = 14'($urandom);
            end
            burst_a(int'($urandom_range(0, 3)), 1'b0, 0, 1'b0);
        end

        b_samp[0] = 12'hA53;
        burst_b(0);
        chk("b_plan_value", 64'(b_dval), 64'h0A53);
        for (int k = 0; k < 8; k++) b_samp[k] = 12'($urandom);
        burst_b(1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
